// File: rtl/regfile_write_arbiter_if.sv
// Signal bundle between the writeback requesters, the decode read path and the
// register-file write arbiter.
interface regfile_write_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             hold;
  logic             alu_valid;
  logic [5:0]       alu_reg;
  logic [31:0]      alu_data;
  logic             alu_ready;
  logic             mem_valid;
  logic [5:0]       mem_reg;
  logic [31:0]      mem_data;
  logic             mem_ready;
  logic             write_en;
  logic [5:0]       wr_reg_num;
  logic [31:0]      write_data;
  logic [5:0]       rd_reg_num;
  logic [31:0]      rf_read_data;
  logic [31:0]      read_data;
  logic [CNT_W-1:0] conflict_cnt;
  logic             last_grant_dbg;

  // Requester/decode side.
  modport master (
    output hold,
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output rd_reg_num, rf_read_data,
    input  alu_ready, mem_ready,
    input  write_en, wr_reg_num, write_data,
    input  read_data, conflict_cnt, last_grant_dbg
  );

  // Arbiter side.
  modport slave (
    input  hold,
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  rd_reg_num, rf_read_data,
    output alu_ready, mem_ready,
    output write_en, wr_reg_num, write_data,
    output read_data, conflict_cnt, last_grant_dbg
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a one-stage
// registered write, decode-path bypass, x0/range filtering and a conflict counter.
module regfile_write_arbiter #(
  parameter int REG_FILE_SIZE = 32,
  parameter int CNT_W         = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  localparam logic [31:0]      RF_SIZE = 32'(REG_FILE_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Handshake: a requester raises valid without looking at ready and holds
  // reg/data stable; the transfer happens at the rising edge where valid & ready.
  src_e             last_grant_q, last_grant_d;
  logic             write_en_q, write_en_d;
  logic [5:0]       wr_reg_num_q, wr_reg_num_d;
  logic [31:0]      write_data_q, write_data_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic             grant_alu;
  logic             grant_mem;
  logic             conflict;
  logic [5:0]       grant_reg;
  logic [31:0]      grant_data;
  logic             grant_legal;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    conflict  = 1'b0;
    // Ready is forced low while reset is asserted, independent of the clock.
    if (rst_n && !bus.hold) begin
      conflict = bus.alu_valid && bus.mem_valid;
      if (conflict) begin
        if (last_grant_q == SRC_MEM) grant_alu = 1'b1;
        else                         grant_mem = 1'b1;
      end else if (bus.alu_valid) begin
        grant_alu = 1'b1;
      end else if (bus.mem_valid) begin
        grant_mem = 1'b1;
      end
    end
  end

  always_comb begin
    grant_reg  = bus.alu_reg;
    grant_data = bus.alu_data;
    if (grant_mem) begin
      grant_reg  = bus.mem_reg;
      grant_data = bus.mem_data;
    end
    grant_legal = (grant_reg != 6'd0) && ({26'd0, grant_reg} < RF_SIZE);
  end

  always_comb begin
    last_grant_d   = last_grant_q;
    write_en_d     = 1'b0;
    wr_reg_num_d   = wr_reg_num_q;
    write_data_d   = write_data_q;
    conflict_cnt_d = conflict_cnt_q;

    if (grant_alu) last_grant_d = SRC_ALU;
    if (grant_mem) last_grant_d = SRC_MEM;

    // Illegal destinations are still accepted; only the enable is suppressed.
    if (grant_alu || grant_mem) begin
      write_en_d   = grant_legal;
      wr_reg_num_d = grant_reg;
      write_data_d = grant_data;
    end

    if (conflict && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q   <= SRC_MEM;
      write_en_q     <= 1'b0;
      wr_reg_num_q   <= 6'd0;
      write_data_q   <= 32'd0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      write_en_q     <= write_en_d;
      wr_reg_num_q   <= wr_reg_num_d;
      write_data_q   <= write_data_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  always_comb begin
    bus.alu_ready      = grant_alu;
    bus.mem_ready      = grant_mem;
    bus.write_en       = write_en_q;
    bus.wr_reg_num     = wr_reg_num_q;
    bus.write_data     = write_data_q;
    bus.conflict_cnt   = conflict_cnt_q;
    bus.last_grant_dbg = last_grant_q;
    // The pending write is visible to decode one edge before it commits.
    if (write_en_q && (bus.rd_reg_num == wr_reg_num_q) && (bus.rd_reg_num != 6'd0)) begin
      bus.read_data = write_data_q;
    end else begin
      bus.read_data = bus.rf_read_data;
    end
  end

endmodule
